// File: rtl/display_overlay_pkg.sv
// Shared defaults and packed-bus slicing helpers for the box overlay.
package display_overlay_pkg;

    localparam int DEFAULT_CW = 12;
    localparam int DEFAULT_DW = 24;

    localparam logic [23:0] DEFAULT_BOX_COLOR = 24'hff00aa;

    // LSB of element idx inside a packed bus of width-wide fields.
    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/display_box_overlay_if.sv
// Configuration bus for display_box_overlay: packed per-box bounds, colours and flags.
interface display_box_overlay_if
    import display_overlay_pkg::*;
#(
    parameter int NUM_BOX = 4,
    parameter int CW      = DEFAULT_CW,
    parameter int DW      = DEFAULT_DW
);
    logic                  cfg_valid;
    logic [NUM_BOX*CW-1:0] cfg_hl;
    logic [NUM_BOX*CW-1:0] cfg_hr;
    logic [NUM_BOX*CW-1:0] cfg_vl;
    logic [NUM_BOX*CW-1:0] cfg_vr;
    logic [NUM_BOX*DW-1:0] cfg_color;
    logic [NUM_BOX-1:0]    cfg_en;
    logic [NUM_BOX-1:0]    cfg_blink;
    logic                  cfg_pending;

    modport master (
        output cfg_valid, cfg_hl, cfg_hr, cfg_vl, cfg_vr, cfg_color, cfg_en, cfg_blink,
        input  cfg_pending
    );

    modport slave (
        input  cfg_valid, cfg_hl, cfg_hr, cfg_vl, cfg_vr, cfg_color, cfg_en, cfg_blink,
        output cfg_pending
    );

endinterface

// File: rtl/box_hit_detect.sv
// Combinational validity and stroke-ring test for one rectangle.
module box_hit_detect #(
    parameter int CW    = 12,
    parameter int THICK = 2
) (
    input  logic [CW-1:0] h,
    input  logic [CW-1:0] v,
    input  logic [CW-1:0] hl,
    input  logic [CW-1:0] hr,
    input  logic [CW-1:0] vl,
    input  logic [CW-1:0] vr,
    input  logic          en,
    output logic          hit
);
    localparam logic [CW:0] EXT = (CW+1)'(THICK - 1);

    logic [CW:0] h_x, v_x, hl_x, hr_x, vl_x, vr_x;
    logic [CW:0] h_lo, h_hi, v_lo, v_hi;
    logic        box_valid, outer, inner;

    // One extra bit keeps hr+THICK-1 from wrapping back to small columns.
    assign h_x  = {1'b0, h};
    assign v_x  = {1'b0, v};
    assign hl_x = {1'b0, hl};
    assign hr_x = {1'b0, hr};
    assign vl_x = {1'b0, vl};
    assign vr_x = {1'b0, vr};

    assign h_lo = (hl_x >= EXT) ? (hl_x - EXT) : '0;
    assign v_lo = (vl_x >= EXT) ? (vl_x - EXT) : '0;
    assign h_hi = hr_x + EXT;
    assign v_hi = vr_x + EXT;

    assign box_valid = en && (hl < hr) && (vl < vr);
    assign outer = (h_x >= h_lo) && (h_x <= h_hi) && (v_x >= v_lo) && (v_x <= v_hi);
    assign inner = (h_x > hl_x) && (h_x < hr_x) && (v_x > vl_x) && (v_x < vr_x);
    assign hit   = box_valid && outer && !inner;

endmodule

// File: rtl/display_box_overlay.sv
// Multi-box rectangle overlay: double-buffered box config, per-box blink, 2-cycle video pipeline.
module display_box_overlay
    import display_overlay_pkg::*;
#(
    parameter int   NUM_BOX      = 4,
    parameter int   CW           = DEFAULT_CW,
    parameter int   DW           = DEFAULT_DW,
    parameter int   THICK        = 2,
    parameter int   BLINK_FRAMES = 16,
    parameter logic VS_POL       = 1'b1
) (
    input  logic                  pixelclk,
    input  logic                  reset_n,
    input  logic [DW-1:0]         i_rgb,
    input  logic                  i_hsync,
    input  logic                  i_vsync,
    input  logic                  i_de,
    input  logic [CW-1:0]         hcount,
    input  logic [CW-1:0]         vcount,
    display_box_overlay_if.slave  cfg,
    output logic [DW-1:0]         o_rgb,
    output logic                  o_hsync,
    output logic                  o_vsync,
    output logic                  o_de
);
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(2 * BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(2 * BLINK_FRAMES - 1);
    localparam logic [FC_W-1:0] FC_HALF = FC_W'(BLINK_FRAMES);

    logic                        vs_prev_reg;
    logic                        vs_active;
    logic                        frame_edge;
    logic                        do_swap;
    logic                        pending_reg;
    logic                        blank_phase;
    logic [FC_W-1:0]             frame_cnt_reg;

    logic [DW-1:0]               rgb_s1_reg;
    logic                        hs_s1_reg;
    logic                        vs_s1_reg;
    logic                        de_s1_reg;
    logic [NUM_BOX-1:0]          hit_s1;
    logic [NUM_BOX-1:0][DW-1:0]  color_s1;

    logic [DW-1:0]               sel_color;
    logic                        any_hit;
    logic [DW-1:0]               rgb_next;

    assign vs_active   = (i_vsync == VS_POL);
    assign frame_edge  = vs_active && !vs_prev_reg;
    assign do_swap     = frame_edge && pending_reg;
    assign blank_phase = (frame_cnt_reg >= FC_HALF);
    assign cfg.cfg_pending = pending_reg;

    // A capture on the swap cycle wins over the clear, so new values stay pending.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            vs_prev_reg   <= 1'b0;
            pending_reg   <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            vs_prev_reg <= vs_active;
            if (cfg.cfg_valid) begin
                pending_reg <= 1'b1;
            end else if (do_swap) begin
                pending_reg <= 1'b0;
            end
            if (frame_edge) begin
                frame_cnt_reg <= (frame_cnt_reg == FC_LAST) ? '0 : frame_cnt_reg + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BOX; gi++) begin : g_box
            logic [CW-1:0] pend_hl_reg, pend_hr_reg, pend_vl_reg, pend_vr_reg;
            logic [CW-1:0] act_hl_reg, act_hr_reg, act_vl_reg, act_vr_reg;
            logic [DW-1:0] pend_color_reg, act_color_reg;
            logic          pend_en_reg, pend_blink_reg;
            logic          act_en_reg, act_blink_reg;
            logic          box_hit;
            logic          hit_s1_reg;
            logic [DW-1:0] color_s1_reg;

            always_ff @(posedge pixelclk or negedge reset_n) begin
                if (!reset_n) begin
                    pend_hl_reg    <= '0;
                    pend_hr_reg    <= '0;
                    pend_vl_reg    <= '0;
                    pend_vr_reg    <= '0;
                    pend_color_reg <= DW'(DEFAULT_BOX_COLOR);
                    pend_en_reg    <= 1'b0;
                    pend_blink_reg <= 1'b0;
                    act_hl_reg     <= '0;
                    act_hr_reg     <= '0;
                    act_vl_reg     <= '0;
                    act_vr_reg     <= '0;
                    act_color_reg  <= DW'(DEFAULT_BOX_COLOR);
                    act_en_reg     <= 1'b0;
                    act_blink_reg  <= 1'b0;
                    hit_s1_reg     <= 1'b0;
                    color_s1_reg   <= '0;
                end else begin
                    if (cfg.cfg_valid) begin
                        pend_hl_reg    <= cfg.cfg_hl[slice_lsb(gi, CW) +: CW];
                        pend_hr_reg    <= cfg.cfg_hr[slice_lsb(gi, CW) +: CW];
                        pend_vl_reg    <= cfg.cfg_vl[slice_lsb(gi, CW) +: CW];
                        pend_vr_reg    <= cfg.cfg_vr[slice_lsb(gi, CW) +: CW];
                        pend_color_reg <= cfg.cfg_color[slice_lsb(gi, DW) +: DW];
                        pend_en_reg    <= cfg.cfg_en[gi];
                        pend_blink_reg <= cfg.cfg_blink[gi];
                    end
                    if (do_swap) begin
                        act_hl_reg    <= pend_hl_reg;
                        act_hr_reg    <= pend_hr_reg;
                        act_vl_reg    <= pend_vl_reg;
                        act_vr_reg    <= pend_vr_reg;
                        act_color_reg <= pend_color_reg;
                        act_en_reg    <= pend_en_reg;
                        act_blink_reg <= pend_blink_reg;
                    end
                    hit_s1_reg   <= box_hit && !(act_blink_reg && blank_phase);
                    color_s1_reg <= act_color_reg;
                end
            end

            box_hit_detect #(
                .CW    (CW),
                .THICK (THICK)
            ) u_hit (
                .h   (hcount),
                .v   (vcount),
                .hl  (act_hl_reg),
                .hr  (act_hr_reg),
                .vl  (act_vl_reg),
                .vr  (act_vr_reg),
                .en  (act_en_reg),
                .hit (box_hit)
            );

            assign hit_s1[gi]   = hit_s1_reg;
            assign color_s1[gi] = color_s1_reg;
        end
    endgenerate

    // Walking from the top index down leaves the lowest hitting box selected.
    always_comb begin
        sel_color = color_s1[0];
        for (int k = NUM_BOX - 1; k >= 0; k--) begin
            if (hit_s1[k]) begin
                sel_color = color_s1[k];
            end
        end
        any_hit  = |hit_s1;
        rgb_next = (de_s1_reg && any_hit) ? sel_color : rgb_s1_reg;
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_s1_reg <= '0;
            hs_s1_reg  <= 1'b0;
            vs_s1_reg  <= 1'b0;
            de_s1_reg  <= 1'b0;
            o_rgb      <= '0;
            o_hsync    <= 1'b0;
            o_vsync    <= 1'b0;
            o_de       <= 1'b0;
        end else begin
            rgb_s1_reg <= i_rgb;
            hs_s1_reg  <= i_hsync;
            vs_s1_reg  <= i_vsync;
            de_s1_reg  <= i_de;
            o_rgb      <= rgb_next;
            o_hsync    <= hs_s1_reg;
            o_vsync    <= vs_s1_reg;
            o_de       <= de_s1_reg;
        end
    end

endmodule

// File: tb/tb_display_box_overlay.sv
// Randomised scoreboard bench for display_box_overlay against a frame-level reference model.
module tb_display_box_overlay;
    import display_overlay_pkg::*;

    localparam int NUM_BOX = 4;
    localparam int CW      = DEFAULT_CW;
    localparam int DW      = DEFAULT_DW;
    localparam int THICK   = 2;
    localparam int BF      = 2;
    localparam int CMAX    = (1 << CW) - 1;

    typedef struct {
        int            hl;
        int            hr;
        int            vl;
        int            vr;
        logic [DW-1:0] color;
        bit            en;
        bit            blink;
    } box_t;

    typedef struct {
        int            tag;
        logic [DW-1:0] rgb;
        bit            hs;
        bit            vs;
        bit            de;
    } exp_t;

    logic          pixelclk = 1'b0;
    logic          reset_n  = 1'b1;
    logic [DW-1:0] i_rgb    = '0;
    logic          i_hsync  = 1'b0;
    logic          i_vsync  = 1'b0;
    logic          i_de     = 1'b0;
    logic [CW-1:0] hcount   = '0;
    logic [CW-1:0] vcount   = '0;
    logic [DW-1:0] o_rgb;
    logic          o_hsync;
    logic          o_vsync;
    logic          o_de;

    display_box_overlay_if #(.NUM_BOX(NUM_BOX), .CW(CW), .DW(DW)) cfg_bus ();

    display_box_overlay #(
        .NUM_BOX      (NUM_BOX),
        .CW           (CW),
        .DW           (DW),
        .THICK        (THICK),
        .BLINK_FRAMES (BF),
        .VS_POL       (1'b1)
    ) dut (
        .pixelclk (pixelclk),
        .reset_n  (reset_n),
        .i_rgb    (i_rgb),
        .i_hsync  (i_hsync),
        .i_vsync  (i_vsync),
        .i_de     (i_de),
        .hcount   (hcount),
        .vcount   (vcount),
        .cfg      (cfg_bus),
        .o_rgb    (o_rgb),
        .o_hsync  (o_hsync),
        .o_vsync  (o_vsync),
        .o_de     (o_de)
    );

    always #5 pixelclk = ~pixelclk;

    box_t stage_cfg [NUM_BOX];
    box_t pend_m    [NUM_BOX];
    box_t act_m     [NUM_BOX];
    bit   pend_flag_m;
    bit   prev_vs_m;
    int   frame_m;
    exp_t sb [$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge pixelclk) cyc++;

    // Expected pixel from the active box list: first enabled, well-formed,
    // unblanked box whose thick outline contains (h,v) supplies the colour.
    function automatic logic [DW-1:0] model_pixel(input logic [DW-1:0] rgb, input int h,
                                                  input int v, input bit de);
        bit blank;
        blank = (frame_m % (2 * BF)) >= BF;
        if (!de) return rgb;
        for (int k = 0; k < NUM_BOX; k++) begin
            box_t b;
            bit   outer, inner;
            b = act_m[k];
            if (!b.en || b.hl >= b.hr || b.vl >= b.vr) continue;
            if (b.blink && blank) continue;
            outer = h >= b.hl - (THICK - 1) && h <= b.hr + (THICK - 1) &&
                    v >= b.vl - (THICK - 1) && v <= b.vr + (THICK - 1);
            inner = h > b.hl && h < b.hr && v > b.vl && v < b.vr;
            if (outer && !inner) return b.color;
        end
        return rgb;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_BOX; k++) begin
            act_m[k].en  = 1'b0;
            pend_m[k].en = 1'b0;
        end
        pend_flag_m = 1'b0;
        prev_vs_m   = 1'b0;
        frame_m     = 0;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic set_box(input int k, input int hl, input int hr, input int vl, input int vr,
                           input logic [DW-1:0] color, input bit en, input bit blink);
        stage_cfg[k].hl    = hl;
        stage_cfg[k].hr    = hr;
        stage_cfg[k].vl    = vl;
        stage_cfg[k].vr    = vr;
        stage_cfg[k].color = color;
        stage_cfg[k].en    = en;
        stage_cfg[k].blink = blink;
    endtask

    task automatic clear_stage();
        for (int k = 0; k < NUM_BOX; k++) set_box(k, 0, 0, 0, 0, '0, 1'b0, 1'b0);
    endtask

    // One pixel cycle: check cfg_pending, drive, queue the expected output, advance the model.
    task automatic step(input bit vs, input bit de, input int h, input int v, input bit cv);
        logic [DW-1:0] rgb;
        bit            hs;
        exp_t          e;
        bit            fedge;
        total++;
        if (cfg_bus.cfg_pending !== pend_flag_m) begin
            bad++;
            $display("FAIL cfg_pending at cycle %0d: got %b, want %b", cyc,
                     cfg_bus.cfg_pending, pend_flag_m);
        end
        rgb = DW'($urandom);
        hs  = 1'($urandom_range(0, 1));
        i_rgb   = rgb;
        i_hsync = hs;
        i_vsync = vs;
        i_de    = de;
        hcount  = CW'(h);
        vcount  = CW'(v);
        cfg_bus.cfg_valid = cv;
        for (int k = 0; k < NUM_BOX; k++) begin
            cfg_bus.cfg_hl[k*CW +: CW]    = CW'(stage_cfg[k].hl);
            cfg_bus.cfg_hr[k*CW +: CW]    = CW'(stage_cfg[k].hr);
            cfg_bus.cfg_vl[k*CW +: CW]    = CW'(stage_cfg[k].vl);
            cfg_bus.cfg_vr[k*CW +: CW]    = CW'(stage_cfg[k].vr);
            cfg_bus.cfg_color[k*DW +: DW] = stage_cfg[k].color;
            cfg_bus.cfg_en[k]             = stage_cfg[k].en;
            cfg_bus.cfg_blink[k]          = stage_cfg[k].blink;
        end
        e.tag = cyc + 2;
        e.rgb = model_pixel(rgb, h, v, de);
        e.hs  = hs;
        e.vs  = vs;
        e.de  = de;
        sb.push_back(e);
        fedge     = vs && !prev_vs_m;
        prev_vs_m = vs;
        if (fedge) begin
            if (pend_flag_m) begin
                act_m       = pend_m;
                pend_flag_m = 1'b0;
            end
            frame_m++;
        end
        if (cv) begin
            pend_m      = stage_cfg;
            pend_flag_m = 1'b1;
        end
        @(negedge pixelclk);
    endtask

    task automatic frame_start(input bit cv_on_edge);
        step(1'b1, 1'b0, 0, 0, cv_on_edge);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    // Visit every pixel of the outline band, including one pixel outside it.
    task automatic probe_box(input int hl, input int hr, input int vl, input int vr);
        for (int v = vl - THICK; v <= vr + THICK; v++) begin
            for (int h = hl - THICK; h <= hr + THICK; h++) begin
                if (h < 0 || h > CMAX || v < 0 || v > CMAX) continue;
                if (h <= hl + 1 || h >= hr - 1 || v <= vl + 1 || v >= vr - 1)
                    step(1'b0, 1'b1, h, v, 1'b0);
            end
        end
    endtask

    task automatic rand_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            int sel, h, v;
            bit de;
            sel = int'($urandom_range(0, 19));
            if (sel == 0)      h = int'($urandom_range(CMAX - 4, CMAX));
            else if (sel == 1) h = int'($urandom_range(0, CMAX));
            else               h = int'($urandom_range(0, 320));
            sel = int'($urandom_range(0, 19));
            if (sel == 0) v = int'($urandom_range(CMAX - 4, CMAX));
            else          v = int'($urandom_range(0, 160));
            de = ($urandom_range(0, 9) != 0);
            step(1'b0, de, h, v, 1'b0);
        end
    endtask

    task automatic rand_cfg();
        for (int k = 0; k < NUM_BOX; k++) begin
            int hl, hr, vl, vr;
            hl = int'($urandom_range(0, 240));
            hr = hl + int'($urandom_range(0, 60)) - 2;
            vl = int'($urandom_range(0, 100));
            vr = vl + int'($urandom_range(0, 50)) - 2;
            if (hr < 0) hr = 0;
            if (vr < 0) vr = 0;
            set_box(k, hl, hr, vl, vr, DW'($urandom), ($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)));
        end
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk("rst_o_rgb", o_rgb, '0);
        chk("rst_o_hsync", DW'(o_hsync), '0);
        chk("rst_o_vsync", DW'(o_vsync), '0);
        chk("rst_o_de", DW'(o_de), '0);
        chk("rst_cfg_pending", DW'(cfg_bus.cfg_pending), '0);
        model_reset();
        i_vsync = 1'b0;
        i_de    = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        @(negedge pixelclk);
        @(negedge pixelclk);
        #2;
        reset_n = 1'b1;
        @(negedge pixelclk);
    endtask

    always @(negedge pixelclk) begin
        if (reset_n) begin
            while (sb.size() > 0 && sb[0].tag <= cyc) begin
                mon_e = sb.pop_front();
                total++;
                if (mon_e.tag != cyc || o_rgb !== mon_e.rgb || o_hsync !== mon_e.hs ||
                    o_vsync !== mon_e.vs || o_de !== mon_e.de) begin
                    bad++;
                    $display("FAIL pixel cycle %0d (due %0d): got rgb=%h hs=%b vs=%b de=%b, want rgb=%h hs=%b vs=%b de=%b",
                             cyc, mon_e.tag, o_rgb, o_hsync, o_vsync, o_de,
                             mon_e.rgb, mon_e.hs, mon_e.vs, mon_e.de);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_hl    = '0;
        cfg_bus.cfg_hr    = '0;
        cfg_bus.cfg_vl    = '0;
        cfg_bus.cfg_vr    = '0;
        cfg_bus.cfg_color = '0;
        cfg_bus.cfg_en    = '0;
        cfg_bus.cfg_blink = '0;
        clear_stage();
        model_reset();

        // Power-on reset.
        #1 reset_n = 1'b0;
        @(negedge pixelclk);
        @(negedge pixelclk);
        chk("por_o_rgb", o_rgb, '0);
        chk("por_o_hsync", DW'(o_hsync), '0);
        chk("por_o_vsync", DW'(o_vsync), '0);
        chk("por_o_de", DW'(o_de), '0);
        chk("por_cfg_pending", DW'(cfg_bus.cfg_pending), '0);
        reset_n = 1'b1;
        @(negedge pixelclk);

        // Nothing configured: pure pass-through.
        frame_start(1'b0);
        rand_pixels(150);

        // Single box written mid-frame; appears only after the next vsync.
        set_box(0, 100, 200, 50, 80, 24'hff00aa, 1'b1, 1'b0);
        rand_pixels(20);
        step(1'b0, 1'b1, 150, 50, 1'b1);
        probe_box(100, 200, 50, 80);
        frame_start(1'b0);
        probe_box(100, 200, 50, 80);
        step(1'b0, 1'b1, 150, 65, 1'b0);

        // Overlap written mid-frame, then a clamp/degenerate set written on the edge cycle.
        set_box(0, 100, 200, 50, 80, 24'h0000ff, 1'b1, 1'b0);
        set_box(1, 40, 100, 50, 80, 24'h00ff00, 1'b1, 1'b0);
        step(1'b0, 1'b1, 100, 60, 1'b1);
        clear_stage();
        set_box(0, 0, 30, 0, 20, 24'h123456, 1'b1, 1'b0);
        set_box(1, 50, 50, 10, 40, 24'h654321, 1'b1, 1'b0);
        set_box(2, 4000, 4095, 100, 140, 24'hc0ffee, 1'b1, 1'b0);
        set_box(3, 10, 60, 10, 60, 24'hdeadbe, 1'b0, 1'b0);
        frame_start(1'b1);
        for (int v = 47; v <= 83; v++) step(1'b0, 1'b1, 100, v, 1'b0);
        probe_box(40, 100, 50, 80);
        frame_start(1'b0);
        probe_box(0, 30, 0, 20);
        probe_box(50, 50, 10, 40);
        probe_box(4000, 4095, 100, 140);
        for (int v = 0; v < 4; v++) begin
            step(1'b0, 1'b1, CMAX, v, 1'b0);
            step(1'b0, 1'b1, CMAX - 1, v, 1'b0);
            step(1'b0, 1'b1, v, CMAX, 1'b0);
        end

        // Blink: box0 blinks with a BF-frame half period, box1 is steady.
        clear_stage();
        set_box(0, 10, 60, 10, 40, 24'haa0000, 1'b1, 1'b1);
        set_box(1, 70, 120, 10, 40, 24'h00bb00, 1'b1, 1'b0);
        step(1'b0, 1'b1, 5, 5, 1'b1);
        for (int f = 0; f < 6; f++) begin
            frame_start(1'b0);
            probe_box(10, 60, 10, 40);
            probe_box(70, 120, 10, 40);
        end

        // Randomised configurations, capture points and pixels.
        for (int it = 0; it < 10; it++) begin
            int mode;
            rand_cfg();
            mode = int'($urandom_range(0, 2));
            rand_pixels(30);
            if (mode == 0) step(1'b0, 1'b1, 120, 40, 1'b1);
            rand_pixels(20);
            frame_start(mode == 1);
            rand_pixels(300);
        end

        // Reset mid-line, then confirm nothing draws until a fresh config + vsync.
        clear_stage();
        set_box(0, 20, 90, 20, 60, 24'h55aa55, 1'b1, 1'b0);
        step(1'b0, 1'b1, 30, 30, 1'b1);
        frame_start(1'b0);
        rand_pixels(40);
        do_reset();
        frame_start(1'b0);
        probe_box(20, 90, 20, 60);
        step(1'b0, 1'b1, 50, 40, 1'b1);
        frame_start(1'b0);
        probe_box(20, 90, 20, 60);

        // Drain the pipeline and make sure every queued result was seen.
        i_de = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        repeat (4) @(negedge pixelclk);
        chk("scoreboard_drain", DW'(sb.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
